// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter sharing one RTC protocol engine between four sources,
// with a per-source burst limit and a completion watchdog.
module rtc_bus_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_rnw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        err,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        proto_start,
  output logic [7:0]  proto_address,
  output logic [7:0]  proto_wdata,
  output logic        proto_rnw,
  input  logic        proto_done,
  input  logic [7:0]  proto_rdata
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [7:0] MaxBurst    = 8'(MAX_BURST);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] last_gnt_q, last_gnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rnw_q, rnw_d;

  logic       other_req;
  logic [3:0] cand;
  logic [3:0] win_oh;
  logic [1:0] win_idx;

  // The current holder is masked only once its burst is used up and someone else waits.
  assign other_req = |(req & ~last_gnt_q);
  assign cand      = ((burst_cnt_q == MaxBurst) && other_req) ? (req & ~last_gnt_q) : req;
  assign win_oh    = cand & (~cand + 4'd1);

  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) win_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    rd_data_d   = rd_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rnw_d       = rnw_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StIssue;
          gnt_d      = win_oh;
          last_gnt_d = win_oh;
          addr_d     = req_addr[{win_idx, 3'b000} +: 8];
          wdata_d    = req_wdata[{win_idx, 3'b000} +: 8];
          rnw_d      = req_rnw[win_idx];
          if (win_oh == last_gnt_q) begin
            // Saturate so a lone requester cannot wrap the counter.
            if (burst_cnt_q < MaxBurst) burst_cnt_d = burst_cnt_q + 8'd1;
          end else begin
            burst_cnt_d = 8'd1;
          end
        end
      end
      StIssue: begin
        state_d  = StWait;
        to_cnt_d = 8'd0;
      end
      StWait: begin
        if (proto_done) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (rnw_q) rd_data_d = proto_rdata;
        end else if (to_cnt_q == TimeoutLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= StIdle;
      gnt_q       <= 4'd0;
      last_gnt_q  <= 4'd0;
      burst_cnt_q <= 8'd0;
      to_cnt_q    <= 8'd0;
      err_q       <= 1'b0;
      rd_data_q   <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      rnw_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rnw_q       <= rnw_d;
    end
  end

  assign gnt           = gnt_q;
  assign ack           = (state_q == StDone) ? gnt_q : 4'd0;
  assign err           = err_q;
  assign rd_data       = rd_data_q;
  assign busy          = (state_q != StIdle);
  assign proto_start   = (state_q == StIssue);
  assign proto_address = addr_q;
  assign proto_wdata   = wdata_q;
  assign proto_rnw     = rnw_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rtc_bus_arbiter;

  localparam int MAX_BURST = 8;
  localparam int TIMEOUT   = 255;

  logic        clk;
  logic        Reset;
  logic [3:0]  req, req_rnw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  gnt, ack;
  logic        err, busy, proto_start, proto_rnw, proto_done;
  logic [7:0]  rd_data, proto_address, proto_wdata, proto_rdata;

  int vectors     = 0;
  int miscompares = 0;

  rtc_bus_arbiter #(
    .MAX_BURST(MAX_BURST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .req          (req),
    .req_rnw      (req_rnw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .ack          (ack),
    .err          (err),
    .rd_data      (rd_data),
    .busy         (busy),
    .proto_start  (proto_start),
    .proto_address(proto_address),
    .proto_wdata  (proto_wdata),
    .proto_rnw    (proto_rnw),
    .proto_done   (proto_done),
    .proto_rdata  (proto_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline counted in cycles since its grant.
  // Cycle 1 is the start cycle; completion may occur from cycle 2 on; the
  // watchdog fires on the TIMEOUT-th cycle of waiting; the ack cycle follows.
  bit         m_valid = 1'b0;
  logic       m_active, m_fin, m_err, m_rnw;
  int         m_src, m_cyc, m_last, m_burst;
  logic [7:0] m_rd, m_addr, m_wdata;

  always @(posedge clk) begin : model
    int         src, cyc, last, burst;
    logic       active, fin, errv, rnw;
    logic [7:0] rd, addr, wd;
    logic [3:0] cand;
    src = m_src; cyc = m_cyc; last = m_last; burst = m_burst;
    active = m_active; fin = m_fin; errv = m_err; rnw = m_rnw;
    rd = m_rd; addr = m_addr; wd = m_wdata;
    if (!Reset) begin
      active = 1'b0; fin = 1'b0; errv = 1'b0; rnw = 1'b0;
      src = 0; cyc = 0; last = -1; burst = 0;
      rd = 8'h00; addr = 8'h00; wd = 8'h00;
      m_valid <= 1'b1;
    end else if (!active) begin
      if (req != 4'b0000) begin
        cand = req;
        if (last >= 0 && burst >= MAX_BURST && (req & ~(4'b0001 << last)) != 4'b0000)
          cand[last] = 1'b0;
        src = 0;
        for (int i = 3; i >= 0; i--) if (cand[i]) src = i;
        if (src == last) burst = (burst < MAX_BURST) ? burst + 1 : burst;
        else burst = 1;
        last = src; active = 1'b1; cyc = 1; fin = 1'b0; errv = 1'b0;
        addr = req_addr[8*src +: 8];
        wd   = req_wdata[8*src +: 8];
        rnw  = req_rnw[src];
      end
    end else if (fin) begin
      active = 1'b0; fin = 1'b0; errv = 1'b0;
    end else begin
      if (cyc >= 2) begin
        if (proto_done) begin
          fin = 1'b1; errv = 1'b0;
          if (rnw) rd = proto_rdata;
        end else if (cyc == TIMEOUT + 1) begin
          fin = 1'b1; errv = 1'b1;
        end
      end
      cyc++;
    end
    m_src <= src; m_cyc <= cyc; m_last <= last; m_burst <= burst;
    m_active <= active; m_fin <= fin; m_err <= errv; m_rnw <= rnw;
    m_rd <= rd; m_addr <= addr; m_wdata <= wd;
  end

  always @(negedge clk) begin : compare
    logic [3:0] e_gnt;
    if (m_valid) begin
      e_gnt = m_active ? (4'b0001 << m_src) : 4'b0000;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("ack", 32'(ack), 32'(m_fin ? e_gnt : 4'b0000));
      chk("err", 32'(err), 32'(m_fin & m_err));
      chk("busy", 32'(busy), 32'(m_active));
      chk("proto_start", 32'(proto_start), 32'(m_active && !m_fin && m_cyc == 1));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("proto_address", 32'(proto_address), 32'(m_addr));
      chk("proto_wdata", 32'(proto_wdata), 32'(m_wdata));
      chk("proto_rnw", 32'(proto_rnw), 32'(m_rnw));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Acts as the protocol engine for one transaction: waits for start, pulses
  // done dly cycles later, then waits for the ack. Returns at the ack cycle.
  task automatic serve(input int dly, input logic [7:0] rdv, output int lat,
                       output logic [3:0] g, output logic [7:0] wd);
    int aw;
    lat = 0;
    while (!proto_start && lat < 20) begin
      tick();
      lat++;
    end
    g  = gnt;
    wd = proto_wdata;
    if (!proto_start) begin
      chk("start_seen", 32'(proto_start), 32'd1);
      return;
    end
    repeat (dly) tick();
    proto_done  = 1'b1;
    proto_rdata = rdv;
    tick();
    proto_done = 1'b0;
    aw = 0;
    while (ack == 4'b0000 && aw < 300) begin
      tick();
      aw++;
    end
    chk("ack_latency", 32'(aw), 32'd0);
  endtask

  initial begin : stim
    int         lat, cnt;
    logic [3:0] g;
    logic [7:0] wd;
    Reset = 1'b0; req = 4'b0000; req_rnw = 4'b0000;
    req_addr = 32'h0; req_wdata = 32'h0; proto_done = 1'b0; proto_rdata = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    Reset = 1'b1;
    tick();

    // Single read from the lowest-priority source
    req = 4'b1000; req_rnw = 4'b1000; req_addr = 32'h2100_0000;
    serve(3, 8'h59, lat, g, wd);
    chk("rd3_start_lat", 32'(lat), 32'd1);
    chk("rd3_gnt", 32'(g), 32'h8);
    chk("rd3_addr", 32'(proto_address), 32'h21);
    chk("rd3_ack", 32'(ack), 32'h8);
    chk("rd3_rdata", 32'(rd_data), 32'h59);
    chk("rd3_err", 32'(err), 32'd0);
    req = 4'b0000;
    tick();

    // Reset asserted while waiting for the engine
    req = 4'b0001; req_rnw = 4'b0000; req_addr = 32'h0000_000A; req_wdata = 32'h0000_0011;
    cnt = 0;
    while (!proto_start && cnt < 20) begin
      tick();
      cnt++;
    end
    tick();
    Reset = 1'b0; req = 4'b0000;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_addr", 32'(proto_address), 32'd0);
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Simultaneous requests from sources 2 and 3
    req = 4'b1100; req_rnw = 4'b1000;
    req_addr = 32'h4140_0000; req_wdata = 32'h00A5_0000;
    serve(1, 8'h3C, lat, g, wd);
    chk("pair_first_gnt", 32'(g), 32'h4);
    chk("pair_first_wdata", 32'(wd), 32'hA5);
    req = 4'b1000;
    serve(1, 8'h3C, lat, g, wd);
    chk("pair_second_gnt", 32'(g), 32'h8);
    chk("pair_second_gap", 32'(lat), 32'd2);
    chk("pair_second_rdata", 32'(rd_data), 32'h3C);

    // Burst limit: sources 2 and 3 held high continuously
    req = 4'b1100;
    for (int k = 0; k < 18; k++) begin
      serve(1, 8'h77, lat, g, wd);
      chk($sformatf("burst_gnt_%0d", k), 32'(g), (k == 8 || k == 17) ? 32'h8 : 32'h4);
    end
    req = 4'b0000;
    tick();

    // Watchdog: engine never completes
    req = 4'b0010; req_rnw = 4'b0010; req_addr = 32'h0000_1000;
    cnt = 0;
    while (!proto_start && cnt < 20) begin
      tick();
      cnt++;
    end
    cnt = 0;
    while (ack == 4'b0000 && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 32'd256);
    chk("to_ack", 32'(ack), 32'h2);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rd_data", 32'(rd_data), 32'h77);
    req = 4'b0000;
    tick();

    // Stray done in idle, then done on the final watchdog cycle
    proto_done = 1'b1; proto_rdata = 8'hEE;
    tick();
    proto_done = 1'b0;
    tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_rd_data", 32'(rd_data), 32'h77);
    req = 4'b0001; req_rnw = 4'b0001; req_addr = 32'h0000_0005;
    serve(TIMEOUT, 8'hC3, lat, g, wd);
    chk("edge_gnt", 32'(g), 32'h1);
    chk("edge_ack", 32'(ack), 32'h1);
    chk("edge_err", 32'(err), 32'd0);
    chk("edge_rd_data", 32'(rd_data), 32'hC3);
    req = 4'b0000;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
